// File: rtl/one_hot_demux.sv
// Purpose: routes one valid/ready input stream to one of CHANNELS registered outputs selected by a one-hot tag; drops and counts illegal tags.
// Latency: 1 cycle from input accept to outValid on the target channel; selError/errCount update 1 cycle after an illegal accept.
// Backpressure: inReady drops only when the target channel is full and its outReady is low; illegal tags are always accepted.
module one_hot_demux #(
    parameter int WIDTH         = 8,
    parameter int CHANNELS      = 4,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        inValid,
    output logic                        inReady,
    input  logic [CHANNELS-1:0]         selOneHot,
    input  logic [WIDTH-1:0]            dataIn,
    output logic [CHANNELS*WIDTH-1:0]   dataOutBus,
    output logic [CHANNELS-1:0]         outValid,
    input  logic [CHANNELS-1:0]         outReady,
    output logic                        selError,
    output logic [ERR_CNT_WIDTH-1:0]    errCount
);

    // Per-channel holding registers and error-tracking state.
    logic [CHANNELS-1:0]        r_valid;
    logic [CHANNELS*WIDTH-1:0]  r_data;
    logic                       r_sel_err;
    logic [ERR_CNT_WIDTH-1:0]   r_err_cnt;

    logic [CHANNELS-1:0]        w_sel_minus1;
    logic                       w_legal;
    logic [CHANNELS-1:0]        w_space;
    logic                       w_tgt_free;
    logic                       w_accept;
    logic [CHANNELS-1:0]        w_load;
    logic                       w_drop;
    logic                       w_cnt_max;

    // A vector is one-hot when it is non-zero and clearing its lowest set bit leaves zero.
    assign w_sel_minus1 = selOneHot - CHANNELS'(1);
    assign w_legal      = (selOneHot != '0) && ((selOneHot & w_sel_minus1) == '0);

    // A channel can take a word when it is empty or is being drained this cycle.
    assign w_space      = ~r_valid | outReady;

    // With a legal select only one bit survives the mask, so the OR picks the target's state.
    assign w_tgt_free   = |(selOneHot & w_space);

    // Illegal words are swallowed unconditionally; inValid deliberately plays no part here.
    assign inReady      = w_legal ? w_tgt_free : 1'b1;

    assign w_accept     = inValid & inReady;
    assign w_load       = (w_accept && w_legal) ? selOneHot : '0;
    assign w_drop       = w_accept & ~w_legal;
    assign w_cnt_max    = &r_err_cnt;

    // Load or drain each channel's holding register; a reload wins over a drain so throughput has no bubble.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_valid <= '0;
            r_data  <= '0;
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (w_load[k]) begin
                    r_data[k*WIDTH +: WIDTH] <= dataIn;
                    r_valid[k]               <= 1'b1;
                end else if (outReady[k]) begin
                    r_valid[k]               <= 1'b0;
                end
            end
        end
    end

    // Pulse selError for each dropped word and count drops, holding at the maximum instead of wrapping.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sel_err <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_sel_err <= w_drop;
            if (w_drop && !w_cnt_max) begin
                r_err_cnt <= r_err_cnt + ERR_CNT_WIDTH'(1);
            end
        end
    end

    assign dataOutBus = r_data;
    assign outValid   = r_valid;
    assign selError   = r_sel_err;
    assign errCount   = r_err_cnt;

endmodule

// File: doc/one_hot_demux.md
# one_hot_demux

Registered one-hot demultiplexer: the distribution counterpart of the one-hot `MUX`. It accepts a single valid/ready input stream tagged with a one-hot destination select and delivers each word to exactly one of CHANNELS output channels. Each channel has its own one-entry holding register and its own valid/ready handshake. Words with an illegal select (no bits set, or more than one bit set) are consumed and dropped, then flagged and counted.

## Interface
- WIDTH, 8, width of each channel's data word
- CHANNELS, 4, number of output channels (≥2)
- ERR_CNT_WIDTH, 8, width of the saturating illegal-select counter
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  system reset; synchronous, active-low
- inValid  input  1  input word and select are valid
- inReady  output  1  block accepts the input this cycle
- selOneHot  input  CHANNELS  one-hot destination select, qualified by inValid
- dataIn  input  WIDTH  input data word
- dataOutBus  output  CHANNELS*WIDTH  channel k occupies bits [(k+1)*WIDTH-1 : k*WIDTH]
- outValid  output  CHANNELS  per-channel holding register is full
- outReady  input  CHANNELS  per-channel downstream ready
- selError  output  1  one-cycle pulse: an illegal-select word was dropped
- errCount  output  ERR_CNT_WIDTH  saturating count of dropped illegal-select words

## Operation
- Legal select: exactly one bit of selOneHot is set. Channel k is the index of that bit.
- Illegal select: zero bits set, or two or more bits set.
- inReady is combinational:
  - legal select to channel k: inReady = !outValid[k] || outReady[k]
  - illegal select: inReady = 1
  - inReady is independent of inValid.
- Accept = inValid && inReady.
- Legal accept to channel k: slice k of dataOutBus loads dataIn and outValid[k] sets. Other channels are untouched.
- Output transfer on channel k = outValid[k] && outReady[k]. It clears outValid[k] unless the same channel is reloaded in that cycle.
- Simultaneous drain and reload of channel k: outValid[k] stays 1 and the data becomes the new word. The result is full throughput with no bubble.
- A full channel with outReady low back-pressures only inputs targeting that channel. The block does no reordering, so a stalled head word blocks all following words.
- Illegal accept: the word is discarded and no channel changes.
  - selError = 1 on the next cycle.
  - errCount increments by 1 and saturates at 2^ERR_CNT_WIDTH-1 (no wrap).
- dataOutBus slices hold their last loaded value after drain. Contents are don't-care while outValid is low, but must be stable.
- Reset (reset == 0 at a clk edge):
  - outValid = 0, dataOutBus = 0, selError = 0, errCount = 0.
  - Any word held mid-operation is lost.
  - While reset is asserted, inReady still follows its combinational rule but no accept takes effect.

## Timing
- Latency: a word accepted at edge N appears with outValid[k] = 1 in the cycle after edge N (1 cycle).
- Throughput: 1 word/cycle aggregate when the target channel is empty or draining.
- selError is asserted for exactly the one cycle after each illegal accept. Back-to-back illegal accepts hold it high for consecutive cycles.
- errCount updates in the same cycle that selError asserts.
- No combinational path from outReady or inValid to any output except inReady (outReady → inReady).
- All outputs other than inReady are registered.

## Test plan
- Reset, then route: after reset release, send 0xA5 with sel=0100.
  - inReady = 1.
  - Next cycle outValid = 0100 and slice 2 = 0xA5.
  - Assert outReady[2] → outValid = 0000 the following cycle.
- Back-pressure: outReady = 0000; send 0x11 to channel 1, then 0x22 to channel 1.
  - Second word sees inReady = 0 and is held upstream; slice 1 stays 0x11.
  - Raise outReady[1] → 0x22 is accepted in that same cycle and outValid[1] stays 1.
- Independent channels: channel 0 full and stalled; send 0x33 to channel 3.
  - Accepted.
  - outValid = 1001, and slice 0 is unchanged.
- Illegal selects: send sel=0000, then sel=0110, back-to-back.
  - inReady = 1 both cycles.
  - outValid unchanged.
  - selError high for 2 consecutive cycles.
  - errCount goes 0 → 1 → 2.
- Saturation: ERR_CNT_WIDTH = 2; send 5 illegal words.
  - errCount = 3 and holds.
  - selError still pulses for each word.
- Mid-operation reset: channels 0 and 2 full; assert reset for 1 cycle with inValid high, sel=0010.
  - outValid = 0000, errCount = 0, dataOutBus = 0.
  - The channel-1 word is not loaded.
